// File: rtl/phy_rx_lanes_deskew.sv
// N-lane serial receiver: per-lane COM symbol alignment and lock, idle stripping, FIFO deskew, word output.
// Optional RX_WORD_COUNT_EN adds a saturating 16-bit count of output words on port word_count.
module phy_rx_lanes_deskew #(
    parameter int               N_LANES      = 2,
    parameter int               SYM_W        = 8,
    parameter logic [SYM_W-1:0] COM          = 8'hBC,
    parameter int               LOCK_COUNT   = 4,
    parameter int               DESKEW_DEPTH = 4
) (
    input  logic                       clk_32f,
    input  logic                       reset,
    input  logic [N_LANES-1:0]         serial_in,
    output logic [N_LANES*SYM_W-1:0]   data_out,
    output logic                       valid_out,
    output logic [N_LANES-1:0]         lane_active,
    output logic                       all_active,
    output logic                       deskew_err
`ifdef RX_WORD_COUNT_EN
    ,
    output logic [15:0]                word_count
`endif
);

    localparam int BW = (SYM_W > 1) ? $clog2(SYM_W) : 1;
    localparam int AW = $clog2(DESKEW_DEPTH);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_LOCKING = 2'd1,
        ST_ACTIVE  = 2'd2
    } state_t;

    logic [N_LANES-1:0]       fifo_empty;
    logic [N_LANES-1:0]       fifo_ovf;
    logic [N_LANES*SYM_W-1:0] pop_data;
    logic                     pop;

    logic [N_LANES*SYM_W-1:0] data_q;
    logic                     valid_q;
    logic                     err_q;

    assign all_active  = &lane_active;
    // A word leaves only when every lane has at least one deskewed symbol waiting.
    assign pop         = all_active && (fifo_empty == '0);
    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign deskew_err  = err_q;

    generate
        for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
            logic [SYM_W-1:0] shift_q;
            logic [SYM_W-1:0] win;
            logic [BW-1:0]    bit_cnt_q;
            logic [BW-1:0]    bit_cnt_d;
            logic [3:0]       com_cnt_q;
            state_t           state_q;
            logic             active_q;
            logic             sym_done;
            logic             push;
            logic             full;
            logic             wr_en;
            logic [SYM_W-1:0] mem [DESKEW_DEPTH];
            logic [AW:0]      wr_ptr_q;
            logic [AW:0]      rd_ptr_q;

            assign win       = {shift_q[SYM_W-2:0], serial_in[gi]};
            assign sym_done  = (bit_cnt_q == BW'(SYM_W - 1));
            assign bit_cnt_d = sym_done ? '0 : bit_cnt_q + 1'b1;

            always_ff @(posedge clk_32f or negedge reset) begin
                if (!reset) begin
                    shift_q   <= '0;
                    bit_cnt_q <= '0;
                    com_cnt_q <= '0;
                    state_q   <= ST_SEARCH;
                    active_q  <= 1'b0;
                end else begin
                    shift_q <= win;
                    case (state_q)
                        ST_SEARCH: begin
                            // Bit-level hunt: the edge completing a COM becomes the symbol boundary.
                            if (win == COM) begin
                                bit_cnt_q <= '0;
                                com_cnt_q <= 4'd1;
                                state_q   <= ST_LOCKING;
                            end
                        end
                        ST_LOCKING: begin
                            bit_cnt_q <= bit_cnt_d;
                            if (sym_done) begin
                                if (win == COM) begin
                                    com_cnt_q <= com_cnt_q + 4'd1;
                                    if (com_cnt_q + 4'd1 == 4'(LOCK_COUNT)) begin
                                        state_q  <= ST_ACTIVE;
                                        active_q <= 1'b1;
                                    end
                                end else begin
                                    com_cnt_q <= '0;
                                    state_q   <= ST_SEARCH;
                                end
                            end
                        end
                        ST_ACTIVE: begin
                            bit_cnt_q <= bit_cnt_d;
                        end
                        default: begin
                            state_q <= ST_SEARCH;
                        end
                    endcase
                end
            end

            assign push  = (state_q == ST_ACTIVE) && sym_done && (win != COM);
            assign full  = ((wr_ptr_q - rd_ptr_q) == (AW+1)'(DESKEW_DEPTH));
            // A full FIFO still accepts a symbol when the same edge pops one out.
            assign wr_en = push && (!full || pop);

            assign fifo_ovf[gi]   = push && full && !pop;
            assign fifo_empty[gi] = (wr_ptr_q == rd_ptr_q);
            assign lane_active[gi] = active_q;
            assign pop_data[gi*SYM_W +: SYM_W] = mem[rd_ptr_q[AW-1:0]];

            always_ff @(posedge clk_32f) begin
                if (wr_en) begin
                    mem[wr_ptr_q[AW-1:0]] <= win;
                end
            end

            always_ff @(posedge clk_32f or negedge reset) begin
                if (!reset) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                end else begin
                    if (wr_en) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                    end
                    if (pop) begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= pop;
            if (pop) begin
                data_q <= pop_data;
            end
            if (|fifo_ovf) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef RX_WORD_COUNT_EN
    logic [15:0] word_cnt_q;

    assign word_count = word_cnt_q;

    // Counted on the pop edge so the count already includes the word shown on data_out.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            word_cnt_q <= '0;
        end else if (pop && (word_cnt_q != 16'hFFFF)) begin
            word_cnt_q <= word_cnt_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_phy_rx_lanes_deskew.sv
// Scoreboard bench for phy_rx_lanes_deskew: symbol-level lane model feeds an expected-word queue, a monitor checks every cycle.
module tb_phy_rx_lanes_deskew;

    localparam int         NL  = 2;
    localparam int         SW  = 8;
    localparam int         LC  = 4;
    localparam int         DD  = 4;
    localparam logic [7:0] COM = 8'hBC;

    logic          clk_32f = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    serial_in = 2'b00;
    logic [15:0]   data_out;
    logic          valid_out;
    logic [1:0]    lane_active;
    logic          all_active;
    logic          deskew_err;
`ifdef RX_WORD_COUNT_EN
    logic [15:0]   word_count;
`endif

    phy_rx_lanes_deskew #(
        .N_LANES(NL), .SYM_W(SW), .COM(COM), .LOCK_COUNT(LC), .DESKEW_DEPTH(DD)
    ) dut (
        .clk_32f(clk_32f),
        .reset(reset),
        .serial_in(serial_in),
        .data_out(data_out),
        .valid_out(valid_out),
        .lane_active(lane_active),
        .all_active(all_active),
        .deskew_err(deskew_err)
`ifdef RX_WORD_COUNT_EN
        ,
        .word_count(word_count)
`endif
    );

    always #5 clk_32f = ~clk_32f;

    int cyc = 0;
    always @(posedge clk_32f) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        int          edg;
    } exp_t;

    exp_t       expq[$];
    int         total = 0;
    int         bad = 0;
    int         nw = 0;
    bit         chk_en = 1'b0;
    bit         abort_flag = 1'b0;
    int         act_e [2];
    int         err_e = 0;
    int         off [2];
    logic [7:0] syms [2][$];
    int         pe [2][$];
    logic [7:0] pd [2][$];
    logic [7:0] fq [2][$];
    bit         bits [2][$];

    // Monitor: #1 after each falling clock edge, or right after reset falls.
    always begin : mon
        exp_t       e;
        logic [1:0] exp_la;
        logic       exp_err;
        @(negedge clk_32f or negedge reset);
        #1;
        if (!reset) begin
            total++;
            if (data_out != 16'h0 || valid_out || lane_active != 2'b00 || all_active || deskew_err) begin
                bad++;
                $display("FAIL reset_outputs: data_out=%h valid=%b lane_active=%b all_active=%b deskew_err=%b, required all zero",
                         data_out, valid_out, lane_active, all_active, deskew_err);
            end
`ifdef RX_WORD_COUNT_EN
            total++;
            if (word_count != 16'h0) begin
                bad++;
                $display("FAIL reset_word_count: got %0d required 0", word_count);
            end
`endif
            if (!abort_flag) begin
                total++;
                if (expq.size() != 0) begin
                    bad++;
                    $display("FAIL lost_words: %0d expected words never appeared, required 0", expq.size());
                end
            end
            expq.delete();
            nw = 0;
        end else if (chk_en) begin
            exp_la[0] = (act_e[0] != 0) && (cyc >= act_e[0]);
            exp_la[1] = (act_e[1] != 0) && (cyc >= act_e[1]);
            exp_err   = (err_e != 0) && (cyc >= err_e);
            total++;
            if (lane_active !== exp_la) begin
                bad++;
                $display("FAIL lane_active @%0d: got %b required %b", cyc, lane_active, exp_la);
            end
            total++;
            if (all_active !== (&exp_la)) begin
                bad++;
                $display("FAIL all_active @%0d: got %b required %b", cyc, all_active, &exp_la);
            end
            total++;
            if (deskew_err !== exp_err) begin
                bad++;
                $display("FAIL deskew_err @%0d: got %b required %b", cyc, deskew_err, exp_err);
            end
            if (valid_out === 1'b1) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid @%0d: data_out=%h, required no word", cyc, data_out);
                end else begin
                    e = expq.pop_front();
                    nw++;
                    total++;
                    if (data_out !== e.data) begin
                        bad++;
                        $display("FAIL word_data @%0d: got %h required %h", cyc, data_out, e.data);
                    end
                    total++;
                    if (cyc != e.edg) begin
                        bad++;
                        $display("FAIL word_time: word %h at cycle %0d required cycle %0d", e.data, cyc, e.edg);
                    end
                    $display("word %h at cycle %0d", data_out, cyc);
                end
            end else if (expq.size() > 0 && expq[0].edg < cyc) begin
                e = expq.pop_front();
                total++;
                bad++;
                $display("FAIL missing_valid @%0d: word %h due at cycle %0d, got valid_out=0", cyc, e.data, e.edg);
            end
`ifdef RX_WORD_COUNT_EN
            total++;
            if (word_count != 16'(nw)) begin
                bad++;
                $display("FAIL word_count @%0d: got %0d required %0d", cyc, word_count, nw);
            end
`endif
        end
    end

    task automatic clr();
        for (int l = 0; l < 2; l++) begin
            syms[l].delete();
            off[l] = 0;
        end
    endtask

    task automatic add(input int l, input logic [7:0] s);
        syms[l].push_back(s);
    endtask

    task automatic add_com(input int l, input int n);
        for (int i = 0; i < n; i++) syms[l].push_back(COM);
    endtask

    function automatic logic [7:0] rnd_data();
        logic [7:0] r;
        r = 8'($urandom_range(0, 255));
        while (r == COM) r = 8'($urandom_range(0, 255));
        return r;
    endfunction

    // Symbol-level reference: lock after LC consecutive COMs, then every non-COM symbol is data;
    // words are formed in order from per-lane queues bounded at DD entries.
    task automatic model(input int base, input int tot);
        for (int l = 0; l < 2; l++) begin
            int cnt;
            bit act;
            cnt = 0;
            act = 1'b0;
            act_e[l] = 0;
            pe[l].delete();
            pd[l].delete();
            fq[l].delete();
            for (int k = 0; k < syms[l].size(); k++) begin
                int e;
                e = base + off[l] + (k + 1) * SW;
                if (e > base + tot) break;
                if (!act) begin
                    if (syms[l][k] == COM) begin
                        cnt++;
                        if (cnt == LC) begin
                            act = 1'b1;
                            act_e[l] = e;
                        end
                    end else begin
                        cnt = 0;
                    end
                end else if (syms[l][k] != COM) begin
                    pe[l].push_back(e);
                    pd[l].push_back(syms[l][k]);
                end
            end
        end
        err_e = 0;
        for (int e = base + 1; e <= base + tot; e++) begin
            bit         pop;
            logic [7:0] d0;
            logic [7:0] d1;
            pop = (act_e[0] != 0) && (act_e[0] < e) && (act_e[1] != 0) && (act_e[1] < e)
                  && (fq[0].size() > 0) && (fq[1].size() > 0);
            if (pop) begin
                d0 = fq[0].pop_front();
                d1 = fq[1].pop_front();
                expq.push_back('{data: {d1, d0}, edg: e});
            end
            for (int l = 0; l < 2; l++) begin
                if (pe[l].size() > 0 && pe[l][0] == e) begin
                    d0 = pd[l].pop_front();
                    void'(pe[l].pop_front());
                    if (fq[l].size() >= DD) begin
                        if (err_e == 0) err_e = e;
                    end else begin
                        fq[l].push_back(d0);
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        @(negedge clk_32f);
        reset = 1'b0;
        repeat (2) @(negedge clk_32f);
        reset = 1'b1;
    endtask

    task automatic run_scn(input int abort_bits);
        int         tot;
        int         base;
        logic [7:0] comv;
        comv = COM;
        tot = 0;
        for (int l = 0; l < 2; l++) begin
            if (off[l] + syms[l].size() * SW > tot) tot = off[l] + syms[l].size() * SW;
        end
        tot += 16;
        for (int l = 0; l < 2; l++) begin
            bits[l].delete();
            for (int i = 0; i < off[l]; i++) bits[l].push_back(1'b0);
            for (int k = 0; k < syms[l].size(); k++) begin
                for (int b = SW - 1; b >= 0; b--) bits[l].push_back(syms[l][k][b]);
            end
            // Pad with aligned idles so no partial data symbol ever completes.
            while (bits[l].size() < tot) begin
                for (int b = SW - 1; b >= 0; b--) bits[l].push_back(comv[b]);
            end
        end
        do_reset();
        base = cyc;
        model(base, tot);
        chk_en = 1'b1;
        for (int j = 0; j < tot; j++) begin
            if (abort_bits > 0 && j == abort_bits) break;
            serial_in = {bits[1][j], bits[0][j]};
            @(negedge clk_32f);
        end
        #2;
        chk_en = 1'b0;
        if (abort_bits > 0) begin
            abort_flag = 1'b1;
            #1;
            reset = 1'b0;
            @(negedge clk_32f);
            @(negedge clk_32f);
            reset = 1'b1;
            abort_flag = 1'b0;
        end
    endtask

    task automatic build_traffic();
        clr();
        add_com(0, LC);
        add_com(1, LC);
        for (int i = 0; i < 8; i++) begin
            add(0, 8'hA0 + 8'(i));
            if (i % 3 == 0) add_com(0, 1);
            add(1, 8'hB0 + 8'(i));
            if (i % 2 == 1) add_com(1, 1);
        end
    endtask

    initial begin
        // Aligned lanes, one word.
        clr();
        add_com(0, LC); add(0, 8'h12);
        add_com(1, LC); add(1, 8'h34);
        run_scn(0);

        // Lane 1 lagging by 3 bit times.
        clr();
        off[1] = 3;
        add_com(0, LC); add(0, 8'h12);
        add_com(1, LC); add(1, 8'h34);
        run_scn(0);

        // Broken COM run on lane 0 restarts the lock count.
        clr();
        add_com(0, 3); add(0, 8'h55); add_com(0, LC); add(0, 8'h66);
        add_com(1, LC); add(1, 8'h77);
        run_scn(0);

        // Lane 0 overflows its FIFO while lane 1 is still searching.
        clr();
        add_com(0, LC);
        for (int i = 0; i < 5; i++) add(0, 8'h11 + 8'(i));
        for (int i = 0; i < 9; i++) add(1, 8'h00);
        add_com(1, LC);
        for (int i = 0; i < 4; i++) add(1, 8'h21 + 8'(i));
        run_scn(0);

        // Continuous traffic with interleaved idles.
        build_traffic();
        run_scn(0);

        // Same traffic, reset mid-word, then a fresh lock.
        build_traffic();
        run_scn(75);
        clr();
        add_com(0, LC); add(0, 8'h12);
        add_com(1, LC); add(1, 8'h34);
        run_scn(0);

        // Randomised skew, data and idle placement.
        for (int it = 0; it < 8; it++) begin
            clr();
            for (int l = 0; l < 2; l++) begin
                off[l] = int'($urandom_range(0, 12));
                add_com(l, LC);
                for (int i = 0; i < 6; i++) begin
                    if ($urandom_range(0, 2) == 0) add_com(l, 1);
                    add(l, rnd_data());
                end
            end
            run_scn(0);
        end

        do_reset();
        @(negedge clk_32f);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
